uart_tx_arbiter: RTL

//  Shares one uart transmitter between N_REQ byte producers (CPU, debug, loaders).

---
 rtl/uart_tx_arbiter_pkg.sv | 37 +++
 rtl/uart_tx_arbiter_rr_select.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter_pkg
//  Brief    : Shared types, constants and helpers for the UART TX arbiter.
//  Revision : 1.0
// ============================================================================

package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_SENDING = 2'd2
    } state_t;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // a + b modulo n, for a, b already in [0, n); n need not be a power of 2
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

    function automatic int wrap_inc(input int v, input int n);
        return wrap_add(v, 1, n);
    endfunction

    // Counter width for the lock timeout; a zero timeout still needs one bit
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
//  Module   : rr_select
//  Brief    : Combinational round-robin finder: first set request bit at or
//             after the pointer, wrapping modulo N.
//  Revision : 1.0
// ============================================================================

module rr_select
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] w_pos;

    // Scan from the farthest offset down so the closest hit is written last
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = IDX_W'(wrap_add(int'(i_ptr), k, N));
            if (i_req[w_pos]) begin
                o_found = 1'b1;
                o_idx   = w_pos;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Brief    : Shares one UART transmitter between N_REQ byte producers with
//             per-byte round-robin and per-message locking.
//  Revision : 1.0
// ============================================================================

module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int WIDTH        = 8,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_last,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    output logic [N_REQ-1:0]           req_ack,
    input  logic                       uart_busy,
    output logic                       uart_start,
    output logic [WIDTH-1:0]           uart_data_tx,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       locked
);

    localparam int   c_IDX_W      = $clog2(N_REQ);
    localparam int   c_CNT_W      = cnt_width(LOCK_TIMEOUT);
    localparam int   c_CNT_LAST   = (LOCK_TIMEOUT > 0) ? (LOCK_TIMEOUT - 1) : 0;
    localparam logic c_TIMEOUT_EN = (LOCK_TIMEOUT > 0);

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_ptr;
    logic [c_IDX_W-1:0]   r_grant;
    logic                 r_locked;
    logic                 r_last;
    logic [N_REQ-1:0]     r_ack;
    logic                 r_start;
    logic [WIDTH-1:0]     r_data;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [N_REQ-1:0]     w_owner;
    logic [N_REQ-1:0]     w_eligible;
    logic                 w_owner_valid;
    logic                 w_found;
    logic [c_IDX_W-1:0]   w_idx;
    logic [WIDTH-1:0]     w_win_data;
    logic                 w_win_last;
    logic                 w_cnt_done;

    // While a message is open only its owner may compete
    assign w_owner       = N_REQ'(1) << r_grant;
    assign w_eligible    = r_locked ? (req_valid & w_owner) : req_valid;
    assign w_owner_valid = |(req_valid & w_owner);
    assign w_win_data    = req_data[w_idx*WIDTH +: WIDTH];
    assign w_win_last    = req_last[w_idx];
    assign w_cnt_done    = (r_cnt == c_CNT_W'(c_CNT_LAST));

    rr_select #(
        .N     (N_REQ),
        .IDX_W (c_IDX_W)
    ) u_rr_select (
        .i_req   (w_eligible),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_grant  <= '0;
            r_locked <= FALSE;
            r_last   <= FALSE;
            r_ack    <= '0;
            r_start  <= FALSE;
            r_data   <= '0;
            r_cnt    <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (!uart_busy && w_found) begin
                        r_data  <= w_win_data;
                        r_last  <= w_win_last;
                        r_grant <= w_idx;
                        r_ack   <= N_REQ'(1) << w_idx;
                        r_start <= TRUE;
                        r_cnt   <= '0;
                        r_state <= ST_ISSUE;
                    end else if (c_TIMEOUT_EN && r_locked && !w_owner_valid) begin
                        // Owner went quiet mid-message: release after the timeout
                        if (w_cnt_done) begin
                            r_locked <= FALSE;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                end

                ST_ISSUE: begin
                    if (uart_busy) begin
                        r_start <= FALSE;
                        r_state <= ST_SENDING;
                    end
                end

                ST_SENDING: begin
                    if (!uart_busy) begin
                        r_ptr    <= c_IDX_W'(wrap_inc(int'(r_grant), N_REQ));
                        r_locked <= !r_last;
                        r_state  <= ST_IDLE;
                    end
                end

                default: begin
                    r_start <= FALSE;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ack      = r_ack;
    assign uart_start   = r_start;
    assign uart_data_tx = r_data;
    assign grant_id     = r_grant;
    assign locked       = r_locked;

endmodule

`default_nettype wire
